// File: rtl/clock_pkg.sv
// Shared types and constants for the clock-setting control block.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } clk_mode_t;

  localparam int unsigned DIV_DEFAULT = 50_000_000;

endpackage

// File: rtl/edge_det.sv
// Rising-edge detector for a synchronous, debounced button level.
module edge_det (
  input  logic clk,
  input  logic n_rst,
  input  logic level_i,
  output logic rise_c_o
);

  logic prev_q;

  // History resets high so a button held through reset release gives no edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= level_i;
    end
  end

  assign rise_c_o = level_i & ~prev_q;

endmodule

// File: rtl/clock_ctrl.sv
// Mode FSM, 1 s prescaler and set-mode blink for a digital clock; drives
// external seconds/minutes/hours counters through their CEN/INC/CLR inputs.
module clock_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       sec_carry,
  input  logic       min_carry,
  output logic       sec_cen,
  output logic       min_cen,
  output logic       hour_cen,
  output logic       min_inc,
  output logic       hour_inc,
  output logic       sec_clr,
  output logic       blink_hour,
  output logic       blink_min,
  output logic [1:0] mode
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned HALF  = DIV / 2;
  localparam int unsigned BLK_W = (HALF > 1) ? $clog2(HALF) : 1;

  clk_mode_t          mode_q, mode_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tick_q, tick_d;
  logic [BLK_W-1:0]   bcnt_q, bcnt_d;
  logic               phase_q, phase_d;
  logic               hour_inc_q, hour_inc_d;
  logic               min_inc_q, min_inc_d;
  logic               mode_rise;
  logic               inc_rise;

  edge_det u_mode_edge (
    .clk      (clk),
    .n_rst    (n_rst),
    .level_i  (btn_mode),
    .rise_c_o (mode_rise)
  );

  edge_det u_inc_edge (
    .clk      (clk),
    .n_rst    (n_rst),
    .level_i  (btn_inc),
    .rise_c_o (inc_rise)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mode_q     <= RUN;
      cnt_q      <= '0;
      tick_q     <= 1'b0;
      bcnt_q     <= '0;
      phase_q    <= 1'b0;
      hour_inc_q <= 1'b0;
      min_inc_q  <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      tick_q     <= tick_d;
      bcnt_q     <= bcnt_d;
      phase_q    <= phase_d;
      hour_inc_q <= hour_inc_d;
      min_inc_q  <= min_inc_d;
    end
  end

  always_comb begin
    mode_d     = mode_q;
    hour_inc_d = 1'b0;
    min_inc_d  = 1'b0;
    cnt_d      = '0;
    tick_d     = 1'b0;
    bcnt_d     = '0;
    phase_d    = 1'b0;

    // A mode edge always wins over a simultaneous inc edge.
    unique case (mode_q)
      RUN: begin
        if (mode_rise) mode_d = SET_HOUR;
      end
      SET_HOUR: begin
        if (mode_rise)     mode_d = SET_MIN;
        else if (inc_rise) hour_inc_d = 1'b1;
      end
      SET_MIN: begin
        if (mode_rise)     mode_d = RUN;
        else if (inc_rise) min_inc_d = 1'b1;
      end
      default: mode_d = RUN;
    endcase

    // Prescaler only advances while staying in RUN, so it restarts from 0.
    if (mode_q == RUN && mode_d == RUN) begin
      tick_d = (cnt_q == CNT_W'(DIV - 1));
      cnt_d  = tick_d ? '0 : cnt_q + CNT_W'(1);
    end

    // Blink phase restarts at 0 on every mode change and is idle in RUN.
    if (mode_d != RUN && mode_d == mode_q) begin
      if (bcnt_q == BLK_W'(HALF - 1)) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d  = bcnt_q + BLK_W'(1);
        phase_d = phase_q;
      end
    end
  end

  assign sec_cen    = tick_q;
  assign min_cen    = tick_q & sec_carry;
  assign hour_cen   = tick_q & sec_carry & min_carry;
  assign hour_inc   = hour_inc_q;
  assign min_inc    = min_inc_q;
  assign sec_clr    = (mode_q != RUN);
  assign blink_hour = phase_q & (mode_q == SET_HOUR);
  assign blink_min  = phase_q & (mode_q == SET_MIN);
  assign mode       = mode_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed bench for clock_ctrl with DIV=4: table of per-cycle vectors plus a
// hand-written reset-during-set sequence.
module tb_clock_ctrl;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       sec_carry = 1'b0;
  logic       min_carry = 1'b0;
  logic       sec_cen, min_cen, hour_cen, min_inc, hour_inc, sec_clr;
  logic       blink_hour, blink_min;
  logic [1:0] mode;
  logic [7:0] act;

  int checks = 0;
  int failures = 0;

  // Output vector order: {sec_cen,min_cen,hour_cen,min_inc,hour_inc,sec_clr,blink_hour,blink_min}
  typedef struct {
    logic       bm;
    logic       bi;
    logic       sc;
    logic       mc;
    logic [1:0] mode;
    logic [7:0] outs;
  } vec_t;

  vec_t vecs[$];

  clock_ctrl #(.DIV(4)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .sec_carry  (sec_carry),
    .min_carry  (min_carry),
    .sec_cen    (sec_cen),
    .min_cen    (min_cen),
    .hour_cen   (hour_cen),
    .min_inc    (min_inc),
    .hour_inc   (hour_inc),
    .sec_clr    (sec_clr),
    .blink_hour (blink_hour),
    .blink_min  (blink_min),
    .mode       (mode)
  );

  always #5 clk = ~clk;

  assign act = {sec_cen, min_cen, hour_cen, min_inc, hour_inc, sec_clr, blink_hour, blink_min};

  function automatic void add(input int n, input logic bm, input logic bi, input logic sc,
                              input logic mc, input logic [1:0] md, input logic [7:0] o);
    vec_t v;
    v.bm = bm; v.bi = bi; v.sc = sc; v.mc = mc; v.mode = md; v.outs = o;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [1:0] emode, input logic [7:0] eout);
    checks++;
    if (mode !== emode || act !== eout) begin
      failures++;
      $display("FAIL %s: got mode=%0d outs=%b, expected mode=%0d outs=%b",
               name, mode, act, emode, eout);
    end
    checks++;
    if (((min_inc & hour_inc) | ((min_inc | hour_inc) & (sec_cen | min_cen | hour_cen))) !== 1'b0) begin
      failures++;
      $display("FAIL %s_excl: inc/cen overlap min_inc=%b hour_inc=%b cen=%b%b%b, expected none",
               name, min_inc, hour_inc, sec_cen, min_cen, hour_cen);
    end
  endtask

  initial begin
    // Idle after reset: tick every 4 cycles
    add(3, 0, 0, 0, 0, 2'd0, 8'h00); add(1, 0, 0, 0, 0, 2'd0, 8'h80);
    add(3, 0, 0, 0, 0, 2'd0, 8'h00); add(1, 0, 0, 0, 0, 2'd0, 8'h80);
    add(3, 0, 0, 0, 0, 2'd0, 8'h00); add(1, 0, 0, 0, 0, 2'd0, 8'h80);
    // Both carries: all three enables together on the tick
    add(3, 0, 0, 1, 1, 2'd0, 8'h00); add(1, 0, 0, 1, 1, 2'd0, 8'hE0);
    // RUN -> SET_HOUR, blink every 2 cycles
    add(1, 1, 0, 0, 0, 2'd1, 8'h04); add(1, 0, 0, 0, 0, 2'd1, 8'h04);
    add(2, 0, 0, 0, 0, 2'd1, 8'h06); add(2, 0, 0, 0, 0, 2'd1, 8'h04);
    // SET_HOUR -> SET_MIN, phase restarts at 0
    add(1, 1, 0, 0, 0, 2'd2, 8'h04); add(1, 0, 0, 0, 0, 2'd2, 8'h04);
    add(2, 0, 0, 0, 0, 2'd2, 8'h05); add(1, 0, 0, 0, 0, 2'd2, 8'h04);
    // Two inc presses in SET_MIN
    add(1, 0, 1, 0, 0, 2'd2, 8'h14); add(1, 0, 0, 0, 0, 2'd2, 8'h05);
    add(1, 0, 1, 0, 0, 2'd2, 8'h15); add(1, 0, 0, 0, 0, 2'd2, 8'h04);
    // Back to RUN; inc ignored; first tick 4 cycles later
    add(1, 1, 0, 0, 0, 2'd0, 8'h00); add(1, 0, 0, 0, 0, 2'd0, 8'h00);
    add(1, 0, 1, 0, 0, 2'd0, 8'h00); add(1, 0, 0, 0, 0, 2'd0, 8'h00);
    add(1, 0, 0, 0, 0, 2'd0, 8'h80);
    // SET_HOUR with inc held 10 cycles: a single hour_inc
    add(1, 1, 0, 0, 0, 2'd1, 8'h04); add(1, 0, 1, 0, 0, 2'd1, 8'h0C);
    add(2, 0, 1, 0, 0, 2'd1, 8'h06); add(2, 0, 1, 0, 0, 2'd1, 8'h04);
    add(2, 0, 1, 0, 0, 2'd1, 8'h06); add(2, 0, 1, 0, 0, 2'd1, 8'h04);
    add(1, 0, 1, 0, 0, 2'd1, 8'h06); add(1, 0, 0, 0, 0, 2'd1, 8'h06);
    // Simultaneous mode and inc edges: mode wins, no pulse
    add(1, 1, 1, 0, 0, 2'd2, 8'h04); add(1, 0, 0, 0, 0, 2'd2, 8'h04);
    add(1, 0, 0, 0, 0, 2'd2, 8'h05);

    step();
    step();
    check("in_reset", 2'd0, 8'h00);
    n_rst = 1'b1;

    foreach (vecs[i]) begin
      btn_mode  = vecs[i].bm;
      btn_inc   = vecs[i].bi;
      sec_carry = vecs[i].sc;
      min_carry = vecs[i].mc;
      step();
      check($sformatf("vec%0d", i + 1), vecs[i].mode, vecs[i].outs);
    end

    // Reset while in SET_MIN with inc held through release
    btn_inc = 1'b1;
    n_rst   = 1'b0;
    #1;
    check("async_rst", 2'd0, 8'h00);
    step();
    check("rst_hold0", 2'd0, 8'h00);
    step();
    check("rst_hold1", 2'd0, 8'h00);
    n_rst = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      check($sformatf("post_rst%0d", c), 2'd0, (c == 4) ? 8'h80 : 8'h00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
